com_bus_arbiter_n: RTL and testbench
====================================

Name: com_bus_arbiter_n

Overview:
Parametrised common-bus arbiter for the N-processor MESI cache system.
- Grants exactly one processor-side bus transaction at a time.
- While a transaction is in flight, grants a separate snoop-response channel to one remote cache snooper or to lower-level memory.
- Generalises the fixed 8-proc arbiter: configurable N, selectable round-robin or fixed priority, cache-over-memory snoop ordering, hold watchdog.

Parameters:
NUM_PROC, 8, number of processor/cache pairs (2..16)
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (index 0 highest)
MAX_HOLD, 64, proc-grant hold cycles before hold_timeout pulses (≥2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
com_bus_req_proc  in  NUM_PROC  per-cache bus request, level, held until done
com_bus_gnt_proc  out  NUM_PROC  one-hot-or-zero proc grant
com_bus_req_snoop  in  NUM_PROC  per-cache snoop-response request
com_bus_gnt_snoop  out  NUM_PROC  one-hot-or-zero snoop grant
mem_snoop_req  in  1  memory requests to supply data
mem_snoop_gnt  out  1  memory snoop grant
bus_busy  out  1  high while any proc grant is held
proc_owner_id  out  $clog2(NUM_PROC)  index of proc owner, 0 when idle
hold_timeout  out  1  one-cycle pulse when hold count reaches MAX_HOLD

Behaviour:
- Reset (sync, rst=1 at edge): all grants 0, bus_busy 0, proc_owner_id 0, hold_timeout 0, hold counter 0, RR pointer set so index 0 wins first. Reset mid-transaction drops all grants at that edge.
- All outputs are registered. A request sampled at edge t is granted in cycle t+1. No combinational req->gnt path.
- Proc FSM, states IDLE and OWNED:
  - IDLE: if any req_proc is set, pick a winner, go OWNED, set gnt[winner], record owner.
  - OWNED and req_proc[owner]=1: hold the grant.
  - OWNED and req_proc[owner]=0: release at this edge. If other requests are pending, grant the next winner at the same edge (zero-bubble handover), else go IDLE.
- Winner selection:
  - ARB_MODE=0: first requester searching upward from last owner+1, wrapping NUM_PROC-1 -> 0. Pointer updates only on a new grant.
  - ARB_MODE=1: lowest set index.
- Snoop channel is active only in OWNED; all snoop grants are 0 in IDLE.
  - Eligible snoopers are req_snoop with bit[owner] masked off; the owner never snoops itself.
  - Cache snoopers have strict priority over memory. mem_snoop_gnt is given only when no eligible cache snoop request is present.
  - Cache snoopers are picked with the same mode and a separate RR pointer.
  - A snoop grant is held while its request stays high. On request drop, re-arbitrate at the same edge.
  - When the proc grant releases, all snoop grants clear at that same edge, even if requests are still high.
  - A new proc owner granted at the handover edge starts with no snoop grant. Snoop arbitration for it begins the next cycle.
- Invariant: at most one of {com_bus_gnt_snoop bits, mem_snoop_gnt} is high.
- Watchdog:
  - Counter clears on each new proc grant and increments each OWNED cycle, saturating at MAX_HOLD.
  - hold_timeout pulses for one cycle when the count first equals MAX_HOLD.
  - The watchdog never forces a release.
- Simultaneous events:
  - Owner drops req in the same cycle another cache raises req: the new request is eligible at that edge.
  - A req that is high and low within one cycle between edges is never seen.
- Width rule: proc_owner_id is zero-extended from the internal index. For NUM_PROC=2 it is 1 bit.

Decomposition:
- Package cache_arb_pkg holds:
  - arb_mode_e {ARB_RR, ARB_FIXED}
  - function id_w(n) returning max(1, $clog2(n))
  - constant MEM_SNOOP_IDX = NUM_PROC, used as the memory slot in debug encodings
- Sub-module arb_pick (combinational), parametrised by width and mode.
  - Inputs: req vector, pointer. Outputs: one-hot winner, any-valid.
  - Instantiated twice: proc channel and snoop channel.

Test Plan:
- Reset and idle: rst=1 for 2 cycles with req_proc=8'hFF. All grants 0 during reset. After release, gnt_proc=8'h01 in the next cycle.
- RR rotation (N=8, mode 0): req_proc=8'b1010_0100 held, each owner drops req after 3 cycles. Grants go 2->5->7->2 with zero idle cycles between owners.
- Fixed priority (mode 1): owner 3 active, req_proc={0,3,6} set. On 3's drop, grant goes to 0, then 6.
- Snoop ordering: owner 1, req_snoop=8'b0001_0010 with mem_snoop_req=1. gnt_snoop=8'h10 (bit 1 masked); mem_snoop_gnt=1 only after cache 4 drops.
- Forced snoop clear: owner drops proc req while snoop 5 is granted. gnt_proc and gnt_snoop both go 0 at the same edge.
- Watchdog (MAX_HOLD=4): owner holds 10 cycles. Exactly one hold_timeout pulse, in the 4th OWNED cycle, and the grant is still held.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types and helpers for the common-bus arbiter and its pick sub-block.
package cache_arb_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    // Index width for n slots, never narrower than one bit.
    function automatic int unsigned id_w(input int unsigned n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

    // Memory occupies the slot just past the last cache in debug encodings.
    function automatic int unsigned mem_snoop_idx(input int unsigned num_proc);
        return num_proc;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner picker: round-robin from ptr_i+1, or fixed lowest-index-first.
module arb_pick import cache_arb_pkg::*; #(
    parameter int unsigned Width = 8,
    parameter arb_mode_e   Mode  = ARB_RR
) (
    input  logic [Width-1:0]           req_i,
    input  logic [id_w(Width)-1:0]     ptr_i,
    output logic [Width-1:0]           gnt_o,
    output logic                       valid_o
);

    localparam int unsigned IdW = id_w(Width);

    logic [IdW-1:0] base;
    logic [IdW-1:0] idx;

    // Fixed priority is round-robin with the pointer pinned at the top slot.
    always_comb begin
        gnt_o   = '0;
        valid_o = |req_i;
        idx     = '0;
        base    = (Mode == ARB_FIXED) ? IdW'(Width - 1) : ptr_i;
        for (int k = int'(Width); k >= 1; k--) begin
            idx = IdW'((int'(base) + k) % int'(Width));
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/com_bus_arbiter_n.sv
// Common-bus arbiter: one processor bus owner at a time plus a snoop-response channel
// shared by the remote caches and memory while the bus is owned.
module com_bus_arbiter_n import cache_arb_pkg::*; #(
    parameter int unsigned NUM_PROC = 8,
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PROC-1:0]           com_bus_req_proc,
    output logic [NUM_PROC-1:0]           com_bus_gnt_proc,
    input  logic [NUM_PROC-1:0]           com_bus_req_snoop,
    output logic [NUM_PROC-1:0]           com_bus_gnt_snoop,
    input  logic                          mem_snoop_req,
    output logic                          mem_snoop_gnt,
    output logic                          bus_busy,
    output logic [id_w(NUM_PROC)-1:0]     proc_owner_id,
    output logic                          hold_timeout
);

    localparam int unsigned IdW  = id_w(NUM_PROC);
    localparam int unsigned CntW = $clog2(MAX_HOLD + 1);
    localparam arb_mode_e   Mode = (ARB_MODE == 0) ? ARB_RR : ARB_FIXED;

    typedef enum logic [0:0] {StIdle, StOwned} proc_st_e;

    proc_st_e            st_q, st_d;
    logic [NUM_PROC-1:0] gnt_proc_q, gnt_proc_d, gnt_snoop_q, gnt_snoop_d;
    logic                mem_gnt_q, mem_gnt_d, busy_q, busy_d, timeout_q, timeout_d;
    logic [IdW-1:0]      owner_q, owner_d, proc_ptr_q, proc_ptr_d, snoop_ptr_q, snoop_ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic [NUM_PROC-1:0] proc_win, snoop_win, snoop_elig;
    logic [IdW-1:0]      proc_win_idx, snoop_win_idx;
    logic                proc_valid, snoop_valid, owner_req, snoop_held;

    assign snoop_elig = com_bus_req_snoop & ~gnt_proc_q;
    assign owner_req  = |(com_bus_req_proc & gnt_proc_q);
    assign snoop_held = |(com_bus_req_snoop & gnt_snoop_q);

    arb_pick #(.Width(NUM_PROC), .Mode(Mode)) u_proc_pick (
        .req_i   (com_bus_req_proc),
        .ptr_i   (proc_ptr_q),
        .gnt_o   (proc_win),
        .valid_o (proc_valid)
    );

    arb_pick #(.Width(NUM_PROC), .Mode(Mode)) u_snoop_pick (
        .req_i   (snoop_elig),
        .ptr_i   (snoop_ptr_q),
        .gnt_o   (snoop_win),
        .valid_o (snoop_valid)
    );

    always_comb begin
        proc_win_idx  = '0;
        snoop_win_idx = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            if (proc_win[i])  proc_win_idx  = IdW'(i);
            if (snoop_win[i]) snoop_win_idx = IdW'(i);
        end
    end

    // Snoop grants default to zero so any release or handover clears them.
    always_comb begin
        st_d        = st_q;
        gnt_proc_d  = gnt_proc_q;
        owner_d     = owner_q;
        proc_ptr_d  = proc_ptr_q;
        snoop_ptr_d = snoop_ptr_q;
        gnt_snoop_d = '0;
        mem_gnt_d   = 1'b0;
        cnt_d       = cnt_q;
        if (st_q == StOwned && owner_req) begin
            if (cnt_q != CntW'(MAX_HOLD)) cnt_d = cnt_q + 1'b1;
            if (snoop_held) begin
                gnt_snoop_d = gnt_snoop_q;
            end else if (mem_gnt_q && mem_snoop_req) begin
                mem_gnt_d = 1'b1;
            end else if (snoop_valid) begin
                gnt_snoop_d = snoop_win;
                snoop_ptr_d = snoop_win_idx;
            end else begin
                mem_gnt_d = mem_snoop_req;
            end
        end else if (proc_valid) begin
            st_d       = StOwned;
            gnt_proc_d = proc_win;
            owner_d    = proc_win_idx;
            proc_ptr_d = proc_win_idx;
            cnt_d      = CntW'(1);
        end else begin
            st_d       = StIdle;
            gnt_proc_d = '0;
            owner_d    = '0;
            cnt_d      = '0;
        end
        busy_d    = (st_d == StOwned);
        timeout_d = (cnt_d == CntW'(MAX_HOLD)) && (cnt_q != CntW'(MAX_HOLD));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= StIdle;
            gnt_proc_q  <= '0;
            gnt_snoop_q <= '0;
            mem_gnt_q   <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            owner_q     <= '0;
            proc_ptr_q  <= IdW'(NUM_PROC - 1);
            snoop_ptr_q <= IdW'(NUM_PROC - 1);
            cnt_q       <= '0;
        end else begin
            st_q        <= st_d;
            gnt_proc_q  <= gnt_proc_d;
            gnt_snoop_q <= gnt_snoop_d;
            mem_gnt_q   <= mem_gnt_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            owner_q     <= owner_d;
            proc_ptr_q  <= proc_ptr_d;
            snoop_ptr_q <= snoop_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign com_bus_gnt_proc  = gnt_proc_q;
    assign com_bus_gnt_snoop = gnt_snoop_q;
    assign mem_snoop_gnt     = mem_gnt_q;
    assign bus_busy          = busy_q;
    assign proc_owner_id     = owner_q;
    assign hold_timeout      = timeout_q;

endmodule

// File: tb/tb_com_bus_arbiter_n.sv
// Bench for com_bus_arbiter_n: a round-robin and a fixed-priority instance share stimulus
// and are checked every cycle against a transaction-level model plus literal expectations.
module tb_com_bus_arbiter_n;

    localparam int N    = 8;
    localparam int MAXH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] rp, rs;
    logic         mr;

    logic [N-1:0] gp [2];
    logic [N-1:0] gs [2];
    logic         mg [2];
    logic         bb [2];
    logic         to [2];
    logic [2:0]   oid [2];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state per instance (0 = round-robin, 1 = fixed): owner/snooper -1 when none,
    // snooper N means memory; tenure counts owned cycles of the current owner.
    int owner [2];
    int pptr [2];
    int sptr [2];
    int sn [2];
    int tenure [2];
    int w;

    always #5 clk = ~clk;

    com_bus_arbiter_n #(.NUM_PROC(N), .ARB_MODE(0), .MAX_HOLD(MAXH)) dut_rr (
        .clk               (clk),
        .rst               (rst),
        .com_bus_req_proc  (rp),
        .com_bus_gnt_proc  (gp[0]),
        .com_bus_req_snoop (rs),
        .com_bus_gnt_snoop (gs[0]),
        .mem_snoop_req     (mr),
        .mem_snoop_gnt     (mg[0]),
        .bus_busy          (bb[0]),
        .proc_owner_id     (oid[0]),
        .hold_timeout      (to[0])
    );

    com_bus_arbiter_n #(.NUM_PROC(N), .ARB_MODE(1), .MAX_HOLD(MAXH)) dut_fx (
        .clk               (clk),
        .rst               (rst),
        .com_bus_req_proc  (rp),
        .com_bus_gnt_proc  (gp[1]),
        .com_bus_req_snoop (rs),
        .com_bus_gnt_snoop (gs[1]),
        .mem_snoop_req     (mr),
        .mem_snoop_gnt     (mg[1]),
        .bus_busy          (bb[1]),
        .proc_owner_id     (oid[1]),
        .hold_timeout      (to[1])
    );

    function automatic int pick(logic [N-1:0] req, int last, int mode);
        if (mode == 1) begin
            for (int i = 0; i < N; i++) if (req[i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                owner[m]  = -1;
                pptr[m]   = N - 1;
                sptr[m]   = N - 1;
                sn[m]     = -1;
                tenure[m] = 0;
            end else if (owner[m] >= 0 && rp[owner[m]]) begin
                tenure[m]++;
                if (!((sn[m] >= 0 && sn[m] < N && rs[sn[m]]) || (sn[m] == N && mr))) begin
                    w = pick(rs & ~(N'(1) << owner[m]), sptr[m], m);
                    if (w >= 0) begin
                        sn[m]   = w;
                        sptr[m] = w;
                    end else begin
                        sn[m] = mr ? N : -1;
                    end
                end
            end else begin
                w        = pick(rp, pptr[m], m);
                sn[m]    = -1;
                owner[m] = w;
                if (w >= 0) begin
                    pptr[m]   = w;
                    tenure[m] = 1;
                end else begin
                    tenure[m] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("gnt_proc[%0d]", m), 32'(gp[m]),
                    (owner[m] >= 0) ? (32'd1 << owner[m]) : 32'd0);
                chk($sformatf("gnt_snoop[%0d]", m), 32'(gs[m]),
                    (sn[m] >= 0 && sn[m] < N) ? (32'd1 << sn[m]) : 32'd0);
                chk($sformatf("mem_gnt[%0d]", m), 32'(mg[m]), 32'(sn[m] == N));
                chk($sformatf("bus_busy[%0d]", m), 32'(bb[m]), 32'(owner[m] >= 0));
                chk($sformatf("owner_id[%0d]", m), 32'(oid[m]),
                    (owner[m] >= 0) ? 32'(owner[m]) : 32'd0);
                chk($sformatf("timeout[%0d]", m), 32'(to[m]), 32'(tenure[m] == MAXH));
                chk($sformatf("snoop_onehot[%0d]", m),
                    32'(int'($countones(gs[m])) + int'(mg[m]) <= 1), 32'd1);
            end
        end
    end

    initial begin
        int pulses [2];
        int at [2];
        int seq [4];
        rst = 1'b1;
        rp  = 8'hFF;
        rs  = '0;
        mr  = 1'b0;

        // Reset with all requests high, then index 0 wins first in both modes
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_gnt_rr_a", 32'(gp[0]), 32'h0);
        chk("rst_gnt_fx_a", 32'(gp[1]), 32'h0);
        @(negedge clk);
        chk("rst_gnt_rr_b", 32'(gp[0]), 32'h0);
        chk("rst_busy_rr", 32'(bb[0]), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_gnt_rr", 32'(gp[0]), 32'h01);
        chk("first_gnt_fx", 32'(gp[1]), 32'h01);
        rp = '0;
        @(negedge clk);
        @(negedge clk);

        // Round-robin rotation with zero-bubble handover
        seq = '{2, 5, 7, 2};
        rp  = 8'hA4;
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("rr_rot_%0d", j), 32'(gp[0]), 32'd1 << seq[j]);
            chk($sformatf("rr_rot_busy_%0d", j), 32'(bb[0]), 32'h1);
            @(negedge clk);
            @(negedge clk);
            rp[seq[j]] = 1'b0;
            @(negedge clk);
            rp[seq[j]] = 1'b1;
        end
        rp = '0;
        @(negedge clk);
        @(negedge clk);

        // Fixed priority: owner 3, then 0, then 6
        rp = 8'h08;
        @(negedge clk);
        rp = 8'h49;
        @(negedge clk);
        @(negedge clk);
        chk("fx_owner3", 32'(gp[1]), 32'h08);
        rp = 8'h41;
        @(negedge clk);
        chk("fx_then0", 32'(gp[1]), 32'h01);
        rp = 8'h40;
        @(negedge clk);
        chk("fx_then6", 32'(gp[1]), 32'h40);
        chk("fx_id6", 32'(oid[1]), 32'd6);
        rp = '0;
        @(negedge clk);
        @(negedge clk);

        // Snoop ordering: owner masked, cache before memory
        rp = 8'h02;
        @(negedge clk);
        rs = 8'h12;
        mr = 1'b1;
        @(negedge clk);
        chk("snp_cache4_rr", 32'(gs[0]), 32'h10);
        chk("snp_cache4_fx", 32'(gs[1]), 32'h10);
        chk("snp_nomem", 32'(mg[0]), 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("snp_cache4_held", 32'(gs[0]), 32'h10);
        rs = 8'h02;
        @(negedge clk);
        chk("snp_mem_gnt", 32'(mg[0]), 32'h1);
        chk("snp_mem_nocache", 32'(gs[0]), 32'h0);

        // Proc release clears a live snoop grant at the same edge
        rs = 8'h20;
        mr = 1'b0;
        @(negedge clk);
        chk("snp_cache5", 32'(gs[0]), 32'h20);
        rp = '0;
        @(negedge clk);
        chk("clr_proc", 32'(gp[0]), 32'h0);
        chk("clr_snoop", 32'(gs[0]), 32'h0);
        rs = '0;
        @(negedge clk);
        @(negedge clk);

        // Watchdog: one pulse in the MAXH-th owned cycle, grant kept
        pulses = '{0, 0};
        at     = '{0, 0};
        rp = 8'h01;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (to[m] === 1'b1) begin
                    pulses[m]++;
                    at[m] = c;
                end
            end
            if (c == MAXH) chk("wd_held", 32'(gp[0]), 32'h01);
        end
        chk("wd_pulses_rr", 32'(pulses[0]), 32'd1);
        chk("wd_cycle_rr", 32'(at[0]), 32'd4);
        chk("wd_pulses_fx", 32'(pulses[1]), 32'd1);
        chk("wd_still_owned", 32'(gp[1]), 32'h01);
        rp = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset mid-transaction drops everything
        rp = 8'h04;
        @(negedge clk);
        rs = 8'h08;
        @(negedge clk);
        chk("mid_snoop_live", 32'(gs[0]), 32'h08);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_proc", 32'(gp[0]), 32'h0);
        chk("mid_rst_snoop", 32'(gs[0]), 32'h0);
        chk("mid_rst_id", 32'(oid[0]), 32'h0);
        rst = 1'b0;
        rp  = '0;
        rs  = '0;
        @(negedge clk);
        @(negedge clk);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
